// File: rtl/sum_window_avg_if.sv
// Sample/average handshake bundle for sum_window_avg.
// master drives samples and consumes averages; slave is the averager.
interface sum_window_avg_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_sum;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_avg;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output i_sum,
        output i_valid,
        input  o_ready,
        input  o_avg,
        input  o_valid,
        output i_ready
    );

    modport slave (
        input  i_sum,
        input  i_valid,
        output o_ready,
        output o_avg,
        output o_valid,
        input  i_ready
    );
endinterface

// File: rtl/sum_window_avg.sv
// Sliding-window average over the last 2**WINDOW_LOG2 accepted samples.
// Running total plus circular buffer; one-entry output register.
module sum_window_avg #(
    parameter int WINDOW_LOG2 = 2,
    parameter int DATA_W      = 8
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    input  logic            i_clr,
    sum_window_avg_if.slave bus
);
    localparam int W     = 1 << WINDOW_LOG2;
    localparam int TOT_W = DATA_W + WINDOW_LOG2;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [WINDOW_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [WINDOW_LOG2-1:0] CNT_LAST = WINDOW_LOG2'(W - 1);

    logic [0:0]             state_q, state_d;
    logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
    logic [WINDOW_LOG2-1:0] wptr_q, wptr_d;
    logic [TOT_W-1:0]       total_q, total_d;
    logic [DATA_W-1:0]      avg_q, avg_d;
    logic                   vld_q, vld_d;
    logic [DATA_W-1:0]      buf_q [W];

    logic              ready;
    logic              accept;
    logic              load;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] oldest;
    logic [TOT_W-1:0]  total_new;

    assign ready       = !vld_q || bus.i_ready;
    assign bus.o_ready = ready;
    assign bus.o_avg   = avg_q;
    assign bus.o_valid = vld_q;

    // Clear wins over a same-cycle accept, so the sample is dropped.
    assign accept = bus.i_valid && ready && !i_clr;

    // Gate the sample so an idle (possibly X) bus never reaches the total.
    assign sample    = accept ? bus.i_sum : '0;
    assign oldest    = buf_q[wptr_q];
    assign total_new = total_q + TOT_W'(sample) - TOT_W'(oldest);

    assign load = accept && ((state_q == RUN) || (cnt_q == CNT_LAST));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        total_d = total_q;
        avg_d   = avg_q;
        vld_d   = vld_q;

        if (i_clr) begin
            state_d = FILL;
            cnt_d   = '0;
            wptr_d  = '0;
            total_d = '0;
            vld_d   = 1'b0;
        end else begin
            if (accept) begin
                total_d = total_new;
                wptr_d  = wptr_q + PTR_ONE;
                if (state_q == FILL) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + PTR_ONE;
                    end
                end
            end

            if (load) begin
                avg_d = total_new[TOT_W-1:WINDOW_LOG2];
                vld_d = 1'b1;
            end else if (vld_q && bus.i_ready) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            wptr_q  <= '0;
            total_q <= '0;
            avg_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            total_q <= total_d;
            avg_q   <= avg_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < W; i++) begin
                buf_q[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < W; i++) begin
                buf_q[i] <= '0;
            end
        end else if (accept) begin
            buf_q[wptr_q] <= bus.i_sum;
        end
    end
endmodule

// File: tb/tb_sum_window_avg.sv
// Scoreboard bench for sum_window_avg with W=4, DATA_W=8.
// Reference model recomputes each window sum from its own sample array.
module tb_sum_window_avg;
    logic clk;
    logic rst_n;
    logic clr;

    sum_window_avg_if #(.DATA_W(8)) bus ();

    sum_window_avg #(
        .WINDOW_LOG2(2),
        .DATA_W     (8)
    ) dut (
        .i_clk   (clk),
        .i_arst_n(rst_n),
        .i_clr   (clr),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_buf [4];
    int m_wp;
    int m_cnt;
    bit m_valid;
    int m_avg;
    int q [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_buf[i] = 0;
        m_wp    = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic step(input bit v, input int s, input bit r, input bit c);
        bit acc;
        bit ld;
        int sum;
        int exp;
        @(negedge clk);
        bus.i_valid = v;
        bus.i_sum   = v ? s[7:0] : 'x;
        bus.i_ready = r;
        clr         = c;
        #1;
        chk("ready", int'(bus.o_ready), int'(!m_valid || r));
        acc = v && (!m_valid || r) && !c;
        ld  = 1'b0;
        if (c) begin
            model_clear();
        end else begin
            if (acc) begin
                m_buf[m_wp] = s;
                m_wp = (m_wp + 1) % 4;
                if (m_cnt < 4) m_cnt++;
                if (m_cnt == 4) begin
                    sum = 0;
                    for (int i = 0; i < 4; i++) sum += m_buf[i];
                    q.push_back(sum / 4);
                    ld = 1'b1;
                end
            end
            if (ld) m_valid = 1'b1;
            else if (m_valid && r) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("valid", int'(bus.o_valid), int'(m_valid));
        if (ld) begin
            exp   = q.pop_front();
            m_avg = exp;
            chk("avg", int'(bus.o_avg), exp);
        end else if (m_valid) begin
            chk("hold", int'(bus.o_avg), m_avg);
        end
        bus.i_valid = 1'b0;
        clr         = 1'b0;
    endtask

    task automatic async_rst();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_avg", int'(bus.o_avg), 0);
        chk("rst_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        m_avg = 0;
    endtask

    initial begin
        int vals [6];
        rst_n       = 1'b0;
        clr         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_sum   = '0;
        bus.i_ready = 1'b0;
        model_clear();
        m_avg = 0;
        #1;
        chk("por_valid", int'(bus.o_valid), 0);
        chk("por_avg", int'(bus.o_avg), 0);
        chk("por_ready", int'(bus.o_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // fill then slide across the pointer wrap
        vals = '{10, 20, 30, 40, 50, 60};
        foreach (vals[i]) step(1'b1, vals[i], 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // full-scale samples
        step(1'b0, 0, 1'b1, 1'b1);
        repeat (8) step(1'b1, 255, 1'b1, 1'b0);

        // backpressure: 70 must wait for i_ready
        step(1'b1, 70, 1'b0, 1'b0);
        step(1'b1, 70, 1'b0, 1'b0);
        step(1'b1, 70, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // clear colliding with a valid sample
        step(1'b1, 99, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, i * 4, 1'b1, 1'b0);

        // async reset with a held result, then mid-fill
        step(1'b1, 200, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        async_rst();
        step(1'b1, 100, 1'b1, 1'b0);
        step(1'b1, 120, 1'b1, 1'b0);
        async_rst();
        repeat (4) step(1'b1, 8, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // mixed traffic
        for (int i = 0; i < 80; i++) begin
            step(($urandom % 4) != 0, int'($urandom % 256),
                 ($urandom % 4) != 0, ($urandom % 25) == 0);
        end

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
